// File: rtl/perm_shuffle_ctrl_pkg.sv
// Shared constants and state encoding for the 7-way permutation sequencer.
package perm_pkg;
  localparam int N = 7;
  localparam int W = 3;
  localparam int RETRY_W = 2;
  localparam logic [RETRY_W-1:0] MAX_RETRY = 2'd2;
  localparam logic [N-1:0] FULL_MASK = 7'h7F;
  // Entry i holds value i; lowest octal digit is entry 0.
  localparam logic [N*W-1:0] IDENTITY_FLAT = 21'o6543210;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;
endpackage

// File: rtl/perm_shuffle_ctrl_if.sv
// Handshake, permutation-unit and table read signals of the shuffle sequencer.
interface perm_shuffle_ctrl_if;
  import perm_pkg::*;
  logic           start;
  logic [W-1:0]   perm_out;
  logic           latch;
  logic [W-1:0]   perm_in;
  logic           busy;
  logic           done;
  logic           table_ok;
  logic           err;
  logic [W-1:0]   rd_idx;
  logic [W-1:0]   rd_val;
  logic [N*W-1:0] table_flat;

  modport master (
    output start, perm_out, rd_idx,
    input  latch, perm_in, busy, done, table_ok, err, rd_val, table_flat
  );

  modport slave (
    input  start, perm_out, rd_idx,
    output latch, perm_in, busy, done, table_ok, err, rd_val, table_flat
  );
endinterface

// File: rtl/perm_shuffle_ctrl.sv
// Freezes the permutation unit, captures its 7 outputs into a table,
// verifies the table is a permutation (with retries) and publishes it.
//
// state  | meaning
// IDLE   | waiting for start; table stable
// LATCH  | one-cycle latch strobe to the permutation unit
// SAMPLE | walk perm_in 0..6, capture perm_out-1
// CHECK  | permutation check, retry or give up
// DONE   | one-cycle done pulse
module perm_shuffle_ctrl
  import perm_pkg::*;
(
  input logic                clk,
  input logic                rst,
  perm_shuffle_ctrl_if.slave bus
);
  state_t               state, state_nxt;
  logic [W-1:0]         idx;
  logic [RETRY_W-1:0]   retry;
  logic [N-1:0]         seen;
  logic [W-1:0]         tbl [N];
  logic                 table_ok_q;
  logic                 err_q;
  logic                 zero_in;
  logic [W-1:0]         entry;
  logic                 check_pass;
  logic                 may_retry;

  // An illegal 0 is stored as 0 but never marks seen, so CHECK fails.
  assign zero_in    = (bus.perm_out == '0);
  assign entry      = zero_in ? '0 : bus.perm_out - W'(1);
  assign check_pass = (seen == FULL_MASK);
  assign may_retry  = (retry < MAX_RETRY);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (bus.start) state_nxt = ST_LATCH;
      ST_LATCH:  state_nxt = ST_SAMPLE;
      ST_SAMPLE: if (idx == W'(N-1)) state_nxt = ST_CHECK;
      ST_CHECK:  state_nxt = (!check_pass && may_retry) ? ST_LATCH : ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      retry      <= '0;
      seen       <= '0;
      table_ok_q <= 1'b1;
      err_q      <= 1'b0;
      for (int i = 0; i < N; i++) tbl[i] <= IDENTITY_FLAT[i*W +: W];
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            table_ok_q <= 1'b0;
            err_q      <= 1'b0;
            retry      <= '0;
            seen       <= '0;
          end
        end
        ST_LATCH: idx <= '0;
        ST_SAMPLE: begin
          tbl[idx] <= entry;
          if (!zero_in) seen[entry] <= 1'b1;
          idx <= idx + W'(1);
        end
        ST_CHECK: begin
          if (check_pass) begin
            table_ok_q <= 1'b1;
          end else if (may_retry) begin
            retry <= retry + RETRY_W'(1);
            seen  <= '0;
          end else begin
            err_q <= 1'b1;
            for (int i = 0; i < N; i++) tbl[i] <= IDENTITY_FLAT[i*W +: W];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.latch    = (state == ST_LATCH);
  assign bus.perm_in  = (state == ST_SAMPLE) ? idx : '0;
  assign bus.busy     = (state != ST_IDLE);
  assign bus.done     = (state == ST_DONE);
  assign bus.table_ok = table_ok_q;
  assign bus.err      = err_q;

  always_comb begin
    bus.rd_val = '0;
    if (bus.rd_idx < W'(N)) bus.rd_val = tbl[bus.rd_idx];
  end

  always_comb begin
    bus.table_flat = '0;
    for (int i = 0; i < N; i++) bus.table_flat[i*W +: W] = tbl[i];
  end
endmodule

// File: tb/tb_perm_shuffle_ctrl.sv
// Self-checking bench: stubbed permutation unit driven from per-attempt value
// tables, compared against a set-based reference model of the shuffle outcome.
module tb_perm_shuffle_ctrl;
  import perm_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  perm_shuffle_ctrl_if bus();
  perm_shuffle_ctrl dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int checks = 0;
  int errors = 0;

  // Stub unit: attempt k (k-th latch since the run began) answers from vals[k-1].
  int vals [3][7];
  int att = 0;
  int att_base = 0;
  int att_idx;
  logic [2:0] pout;

  always @(negedge clk) if (bus.latch) att <= att + 1;

  always_comb begin
    att_idx = att - att_base - 1;
    if (att_idx < 0) att_idx = 0;
    if (att_idx > 2) att_idx = 2;
    pout = 3'(vals[att_idx][bus.perm_in]);
  end
  assign bus.perm_out = pout;

  int exp_tbl [7];
  int exp_att;
  bit exp_ok;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Outcome: first attempt whose values are exactly {1..7} wins; else identity + err.
  task automatic predict();
    int cnt [8];
    bit good;
    exp_ok  = 1'b0;
    exp_att = 3;
    for (int a = 0; a < 3; a++) begin
      if (!exp_ok) begin
        for (int v = 0; v < 8; v++) cnt[v] = 0;
        for (int i = 0; i < 7; i++) cnt[vals[a][i]]++;
        good = (cnt[0] == 0);
        for (int v = 1; v < 8; v++) if (cnt[v] != 1) good = 1'b0;
        if (good) begin
          exp_ok  = 1'b1;
          exp_att = a + 1;
          for (int i = 0; i < 7; i++) exp_tbl[i] = vals[a][i] - 1;
        end
      end
    end
    if (!exp_ok) for (int i = 0; i < 7; i++) exp_tbl[i] = i;
  endtask

  function automatic logic [20:0] flat_of(input int t [7]);
    logic [20:0] f;
    f = '0;
    for (int i = 0; i < 7; i++) f[i*3 +: 3] = 3'(t[i]);
    return f;
  endfunction

  task automatic rand_perm(input int a);
    int t, j;
    for (int i = 0; i < 7; i++) vals[a][i] = i + 1;
    for (int i = 6; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = vals[a][i]; vals[a][i] = vals[a][j]; vals[a][j] = t;
    end
  endtask

  task automatic readback();
    for (int i = 0; i < 8; i++) begin
      bus.rd_idx = 3'(i);
      #1;
      check("rd_val", {29'd0, bus.rd_val}, (i < 7) ? exp_tbl[i] : 0);
    end
    bus.rd_idx = 3'd0;
  endtask

  task automatic run(input bit pulse_start);
    int ndone, nlat, done_cyc;
    predict();
    att_base = att;
    @(posedge clk); #1; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    ndone = 0; nlat = 0; done_cyc = -1;
    for (int c = 1; c <= 40; c++) begin
      if (c == 1) begin
        check("busy_c1", {31'd0, bus.busy}, 1);
        check("ok_cleared", {31'd0, bus.table_ok}, 0);
        check("err_cleared", {31'd0, bus.err}, 0);
      end
      if (bus.latch) nlat++;
      if (bus.done) begin
        ndone++;
        if (done_cyc < 0) begin
          done_cyc = c;
          check("table_flat", {11'd0, bus.table_flat}, {11'd0, flat_of(exp_tbl)});
          check("table_ok", {31'd0, bus.table_ok}, {31'd0, exp_ok});
          check("err", {31'd0, bus.err}, {31'd0, !exp_ok});
        end
      end
      bus.start = pulse_start && (c == 3 || c == 9);
      @(posedge clk); #1;
    end
    check("done_cycle", done_cyc, 10 + 9 * (exp_att - 1));
    check("latch_count", nlat, exp_att);
    check("done_count", ndone, 1);
    check("busy_idle", {31'd0, bus.busy}, 0);
    readback();
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.rd_idx = 3'd0;
    for (int a = 0; a < 3; a++) for (int i = 0; i < 7; i++) vals[a][i] = 7 - i;

    // Reset state
    #23;
    for (int i = 0; i < 7; i++) exp_tbl[i] = i;
    check("rst_table_ok", {31'd0, bus.table_ok}, 1);
    check("rst_busy", {31'd0, bus.busy}, 0);
    check("rst_err", {31'd0, bus.err}, 0);
    check("rst_latch", {31'd0, bus.latch}, 0);
    check("rst_perm_in", {29'd0, bus.perm_in}, 0);
    readback();
    rst = 1'b1;

    // Stub 7-perm_in
    run(1'b0);

    // Stub always 3: retries exhausted
    for (int a = 0; a < 3; a++) for (int i = 0; i < 7; i++) vals[a][i] = 3;
    run(1'b0);

    // Bad first attempt, good second
    rand_perm(1);
    run(1'b0);

    // Illegal zero on first attempt, duplicates on second, good third
    vals[0] = '{0, 2, 3, 4, 5, 6, 7};
    vals[1] = '{1, 1, 3, 4, 5, 6, 7};
    rand_perm(2);
    run(1'b0);

    // Start pulses while busy are ignored
    rand_perm(0);
    run(1'b1);

    // Reset mid-run at cycle 5
    rand_perm(0);
    att_base = att;
    @(posedge clk); #1; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    for (int c = 1; c < 5; c++) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    for (int i = 0; i < 7; i++) exp_tbl[i] = i;
    check("mid_rst_busy", {31'd0, bus.busy}, 0);
    check("mid_rst_latch", {31'd0, bus.latch}, 0);
    check("mid_rst_table", {11'd0, bus.table_flat}, {11'd0, flat_of(exp_tbl)});
    check("mid_rst_ok", {31'd0, bus.table_ok}, 1);
    #1; rst = 1'b1;
    run(1'b0);

    // Randomized attempts
    for (int r = 0; r < 10; r++) begin
      for (int a = 0; a < 3; a++) begin
        if ($urandom_range(1, 0) == 1) rand_perm(a);
        else for (int i = 0; i < 7; i++) vals[a][i] = $urandom_range(7, 0);
      end
      run($urandom_range(1, 0) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
